// File: rtl/l1_trace_issuer.sv
// L1-side request issuer: buffers loader-supplied trace entries in a FIFO and
// presents them one at a time to the cache controller, capturing read responses.
module l1_trace_issuer #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int CMD_W      = 2,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 255,
  parameter int READ_CMD   = 0,
  parameter int WRITE_CMD  = 1,
  parameter int IFETCH_CMD = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [CMD_W-1:0]  load_cmd,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              stall,
  input  logic              L1ack,
  output logic              L1valid,
  output logic [CMD_W-1:0]  L1cmd,
  output logic [ADDR_W-1:0] L1addr,
  inout  wire  [DATA_W-1:0] L1data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  issued_cnt,
  output logic              done,
  output logic              timeout_err,
  output logic [1:0]        o_dbg_state
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0]  TO_LIM = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CMD_W-1:0] C_RD   = CMD_W'(READ_CMD);
  localparam logic [CMD_W-1:0] C_WR   = CMD_W'(WRITE_CMD);
  localparam logic [CMD_W-1:0] C_IF   = CMD_W'(IFETCH_CMD);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT_RD = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [CMD_W-1:0]  r_mem_cmd  [DEPTH];
  logic [ADDR_W-1:0] r_mem_addr [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic              r_mem_last [DEPTH];

  logic [PTR_W:0]    r_wr_ptr, r_rd_ptr;
  logic [1:0]        r_state;
  logic [CMD_W-1:0]  r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_last;
  logic [TO_W-1:0]   r_wait_cnt;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_timeout;

  logic [PTR_W:0]    w_count;
  logic              w_empty, w_full, w_more;
  logic              w_push, w_pop, w_is_rd, w_to_hit, w_rd_end, w_ld;
  logic [PTR_W-1:0]  w_ld_idx;
  logic [1:0]        w_state_nxt;

  // Handshakes: a load transfers on an edge where load_valid & load_ready;
  // a request transfers on an edge where L1valid & !stall. Both sides hold
  // their payload stable until the transfer edge.
  assign w_count    = r_wr_ptr - r_rd_ptr;
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]) &&
                      (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]);
  assign w_more     = (w_count >= (PTR_W+1)'(2));
  assign load_ready = !w_full && (r_state != S_DONE);
  assign w_push     = load_valid && load_ready;
  assign w_pop      = (r_state == S_ISSUE) && !stall;
  assign w_is_rd    = (r_cmd == C_RD) || (r_cmd == C_IF);
  assign w_to_hit   = (TIMEOUT > 0) && (r_wait_cnt == TO_LIM);
  assign w_rd_end   = (r_state == S_WAIT_RD) && (L1ack || w_to_hit);
  // While issuing, the presented entry is still the FIFO head, so the
  // follow-on request comes from the slot after it.
  assign w_ld_idx   = r_rd_ptr[PTR_W-1:0] + PTR_W'(r_state == S_ISSUE);

  always_comb begin
    w_state_nxt = r_state;
    w_ld        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_ld        = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!stall) begin
          if (w_is_rd)     w_state_nxt = S_WAIT_RD;
          else if (r_last) w_state_nxt = S_DONE;
          else if (w_more) w_ld        = 1'b1;
          else             w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_RD: begin
        if (w_rd_end) begin
          if (r_last) w_state_nxt = S_DONE;
          else if (!w_empty) begin
            w_ld        = 1'b1;
            w_state_nxt = S_ISSUE;
          end else w_state_nxt = S_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_cmd[r_wr_ptr[PTR_W-1:0]]  <= load_cmd;
      r_mem_addr[r_wr_ptr[PTR_W-1:0]] <= load_addr;
      r_mem_data[r_wr_ptr[PTR_W-1:0]] <= load_data;
      r_mem_last[r_wr_ptr[PTR_W-1:0]] <= load_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cmd      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_last     <= 1'b0;
      r_wait_cnt <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_cnt      <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ld) begin
        r_cmd   <= r_mem_cmd[w_ld_idx];
        r_addr  <= r_mem_addr[w_ld_idx];
        r_wdata <= r_mem_data[w_ld_idx];
        r_last  <= r_mem_last[w_ld_idx];
      end
      if (r_state != S_WAIT_RD) r_wait_cnt <= '0;
      else if (!w_rd_end)       r_wait_cnt <= r_wait_cnt + TO_W'(1);
      r_rd_valid <= (r_state == S_WAIT_RD) && L1ack;
      if ((r_state == S_WAIT_RD) && L1ack) r_rd_data <= L1data;
      // An ack arriving on the limit cycle still counts as a good read.
      if ((r_state == S_WAIT_RD) && w_to_hit && !L1ack) r_timeout <= 1'b1;
      if (w_pop && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign L1valid     = (r_state == S_ISSUE);
  assign L1cmd       = r_cmd;
  assign L1addr      = r_addr;
  assign L1data      = ((r_state == S_ISSUE) && (r_cmd == C_WR)) ? r_wdata : {DATA_W{1'bz}};
  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_data;
  assign issued_cnt  = r_cnt;
  assign done        = (r_state == S_DONE);
  assign timeout_err = r_timeout;
  assign o_dbg_state = r_state;
endmodule
